modport_driver: RTL and testbench
=================================

MODPORT_DRIVER -- requirements
Module: modport_driver

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 p2md_rstn  in  1  reset, asynchronous, active-low.
REQ-003 en_n  in  1  active-low enable; high freezes sequencing and forces idle outputs.
REQ-004 currLtssmState  in  LTSSM_State  LTSSM state; selects which ordered set (OS) is driven.
REQ-005 ts1Bytes1Thru5  in  40  TS1 symbols 1..5; [7:0]=sym1 ... [39:32]=sym5.
REQ-006 ts2Bytes1Thru5  in  40  TS2 symbols 1..5, same packing.
REQ-007 rxdata  out  8  emitted symbol byte.
REQ-008 rxdatak  out  1  1 = rxdata is a K-symbol.
REQ-009 rxvalid  out  1  1 = rxdata/rxdatak carry an OS symbol.
REQ-010 finishedOs  out  1  one-cycle pulse on the cycle after the last symbol of an OS is driven.

Function
REQ-011 Internal latched state localLtssmState, pointer seqPtr (0..15), and length seqPtrMax derived from localLtssmState: POLLING_ACTIVE -> 4 (SKP OS); POLLING_ACTIVE_START_TS1 -> 16 (TS1); POLLING_CONFIG -> 16 (TS2); any other state -> 1 (idle).
REQ-012 SKP OS: sym0=COM, sym1..3=SKP; rxdatak=1 on all four.
REQ-013 TS1 OS: sym0=COM (K), sym1..5 from captured ts1Bytes1Thru5 (D), sym6..15=TS1ID (D).
REQ-014 TS2 OS: as TS1 with captured ts2Bytes1Thru5 and TS2ID.
REQ-015 Idle state: rxdata=0x00, rxdatak=0, rxvalid=0 each cycle.
REQ-016 Outputs are registered: on each enabled edge, rxdata/rxdatak/rxvalid <= symbol[seqPtr] of the OS for localLtssmState; rxvalid=1 for SKP/TS1/TS2.
REQ-017 When seqPtr==0 on an enabled edge, the relevant 40-bit TS field is captured; symbols 1..5 of that OS come from the capture, so mid-OS input changes do not affect it.
REQ-018 Pointer: if seqPtr==seqPtrMax-1, seqPtr<=0 (OS boundary); else seqPtr<=seqPtr+1.
REQ-019 At an OS boundary: finishedOs<=1; if currLtssmState!=localLtssmState, localLtssmState<=currLtssmState and seqPtrMax recomputed; otherwise unchanged. finishedOs<=0 on all other edges.
REQ-020 State changes never truncate an OS; the new OS starts at sym0 on the edge after the boundary.
REQ-021 Idle state (max=1) makes every enabled edge a boundary, so a new state is adopted in 1 cycle.
REQ-022 en_n=1: seqPtr<=0, rxvalid<=0, rxdata<=0, rxdatak<=0, finishedOs<=0, localLtssmState unchanged; an interrupted OS restarts at sym0 when en_n returns low.

Reset
REQ-023 p2md_rstn=0 immediately forces: rxdata=0x00, rxdatak=0, rxvalid=0, finishedOs=0, seqPtr=0, localLtssmState=DETECT_QUIET, seqPtrMax=1, TS captures=0.
REQ-024 Reset asserted mid-OS aborts it; after release, sequencing resumes from idle per REQ-021.

Structure
REQ-025 Shared package ozdefs_pkg holds: LTSSM_State enum (DETECT_QUIET=0, DETECT_ACTIVE=1, POLLING_ACTIVE=2, POLLING_ACTIVE_START_TS1=3, POLLING_CONFIG=4, 4-bit base), COM=8'hBC, SKP=8'h1C, TS1ID=8'h4A, TS2ID=8'h45.
REQ-026 One sub-module, os_symbol_sel: combinational (state, seqPtr, captured TS bytes) -> {data, k, valid}; top holds pointer, latch, capture and output registers.

Verification
REQ-027 Reset, en_n=0, state POLLING_ACTIVE -> edge 1 latches state; next 4 edges drive BC/1C/1C/1C, k=1, valid=1; finishedOs pulses; repeats.
REQ-028 State POLLING_ACTIVE_START_TS1, ts1Bytes1Thru5=40'h0504030201 -> 16 symbols BC(k=1),01,02,03,04,05,4A x10 (k=0), valid=1 throughout.
REQ-029 Switch POLLING_ACTIVE_START_TS1 -> POLLING_CONFIG at TS1 sym 7 -> TS1 completes all 16 symbols, then TS2 begins with BC, 6th symbol onward 45.
REQ-030 Change ts1Bytes1Thru5 during TS1 sym 3 -> current OS keeps old sym3..5; next TS1 carries new values.
REQ-031 en_n=1 for 3 cycles mid-SKP -> valid=0, data=00; on en_n=0 SKP restarts at BC.
REQ-032 p2md_rstn low asynchronously mid-TS2 -> outputs 0 without a clock edge; state DETECT_QUIET -> idle, valid=0.

Source files
------------

// File: rtl/ozdefs_pkg.sv
// Shared LTSSM state encoding, ordered-set symbol constants and
// the per-state ordered-set length used by the modport_driver block.
package ozdefs_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET             = 4'd0,
    DETECT_ACTIVE            = 4'd1,
    POLLING_ACTIVE           = 4'd2,
    POLLING_ACTIVE_START_TS1 = 4'd3,
    POLLING_CONFIG           = 4'd4
  } LTSSM_State;

  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [7:0] SKP   = 8'h1C;
  localparam logic [7:0] TS1ID = 8'h4A;
  localparam logic [7:0] TS2ID = 8'h45;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       valid;
  } sym_t;

  function automatic logic [4:0] os_len(input LTSSM_State s);
    unique case (1'b1)
      s == POLLING_ACTIVE:           os_len = 5'd4;
      s == POLLING_ACTIVE_START_TS1: os_len = 5'd16;
      s == POLLING_CONFIG:           os_len = 5'd16;
      default:                       os_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/modport_driver_if.sv
// Symbol stream produced by modport_driver: byte, K flag, valid
// and end-of-ordered-set pulse.
interface modport_driver_if;
  logic [7:0] rxdata;
  logic       rxdatak;
  logic       rxvalid;
  logic       finishedOs;

  modport master (
    output rxdata,
    output rxdatak,
    output rxvalid,
    output finishedOs
  );

  modport slave (
    input rxdata,
    input rxdatak,
    input rxvalid,
    input finishedOs
  );
endinterface

// File: rtl/os_symbol_sel.sv
// Combinational lookup of one ordered-set symbol from the latched
// LTSSM state, the symbol pointer and the captured TS bytes.
module os_symbol_sel
  import ozdefs_pkg::*;
(
  input  LTSSM_State  state,
  input  logic [3:0]  seq_ptr,
  input  logic [39:0] ts1_cap,
  input  logic [39:0] ts2_cap,
  output sym_t        sym
);

  function automatic sym_t ts_sym(
    input logic [3:0]  p,
    input logic [39:0] b,
    input logic [7:0]  id
  );
    sym_t r;
    r.k     = 1'b0;
    r.valid = 1'b1;
    unique case (p)
      4'd0:    begin r.data = COM; r.k = 1'b1; end
      4'd1:    r.data = b[7:0];
      4'd2:    r.data = b[15:8];
      4'd3:    r.data = b[23:16];
      4'd4:    r.data = b[31:24];
      4'd5:    r.data = b[39:32];
      default: r.data = id;
    endcase
    return r;
  endfunction

  always_comb begin
    sym = '0;
    unique case (1'b1)
      state == POLLING_ACTIVE: begin
        sym.data  = (seq_ptr == 4'd0) ? COM : SKP;
        sym.k     = 1'b1;
        sym.valid = 1'b1;
      end
      state == POLLING_ACTIVE_START_TS1:
        sym = ts_sym(seq_ptr, ts1_cap, TS1ID);
      state == POLLING_CONFIG:
        sym = ts_sym(seq_ptr, ts2_cap, TS2ID);
      default: sym = '0;
    endcase
  end

endmodule

// File: rtl/modport_driver.sv
// Ordered-set generator: sequences SKP/TS1/TS2 symbols for the
// latched LTSSM state, switching states only at OS boundaries.
module modport_driver
  import ozdefs_pkg::*;
(
  input  logic        clk,
  input  logic        p2md_rstn,
  input  logic        en_n,
  input  LTSSM_State  currLtssmState,
  input  logic [39:0] ts1Bytes1Thru5,
  input  logic [39:0] ts2Bytes1Thru5,
  modport_driver_if.master rx
);

  LTSSM_State  local_state;
  logic [3:0]  seq_ptr;
  logic [4:0]  seq_ptr_max;
  logic [39:0] ts1_cap;
  logic [39:0] ts2_cap;
  logic        last;
  sym_t        sym;

  assign seq_ptr_max = os_len(local_state);
  assign last = ({1'b0, seq_ptr} == seq_ptr_max - 5'd1);

  os_symbol_sel u_sel (
    .state   (local_state),
    .seq_ptr (seq_ptr),
    .ts1_cap (ts1_cap),
    .ts2_cap (ts2_cap),
    .sym     (sym)
  );

  always_ff @(posedge clk or negedge p2md_rstn) begin
    if (!p2md_rstn) begin
      rx.rxdata     <= 8'h00;
      rx.rxdatak    <= 1'b0;
      rx.rxvalid    <= 1'b0;
      rx.finishedOs <= 1'b0;
      seq_ptr       <= 4'd0;
      local_state   <= DETECT_QUIET;
      ts1_cap       <= '0;
      ts2_cap       <= '0;
    end else if (en_n) begin
      rx.rxdata     <= 8'h00;
      rx.rxdatak    <= 1'b0;
      rx.rxvalid    <= 1'b0;
      rx.finishedOs <= 1'b0;
      seq_ptr       <= 4'd0;
    end else begin
      rx.rxdata  <= sym.data;
      rx.rxdatak <= sym.k;
      rx.rxvalid <= sym.valid;
      // sym0 is always COM, so capturing here never races sym1..5
      if (seq_ptr == 4'd0) begin
        ts1_cap <= ts1Bytes1Thru5;
        ts2_cap <= ts2Bytes1Thru5;
      end
      if (last) begin
        seq_ptr       <= 4'd0;
        rx.finishedOs <= 1'b1;
        if (currLtssmState != local_state)
          local_state <= currLtssmState;
      end else begin
        seq_ptr       <= seq_ptr + 4'd1;
        rx.finishedOs <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modport_driver.sv
// Directed bench for modport_driver: SKP, TS1, TS2, enable gating,
// capture stability, state switching and asynchronous reset.
module tb_modport_driver;
  import ozdefs_pkg::*;

  logic        clk;
  logic        p2md_rstn;
  logic        en_n;
  LTSSM_State  st;
  logic [39:0] ts1;
  logic [39:0] ts2;
  int          total;
  int          bad;

  modport_driver_if rx ();

  modport_driver dut (
    .clk            (clk),
    .p2md_rstn      (p2md_rstn),
    .en_n           (en_n),
    .currLtssmState (st),
    .ts1Bytes1Thru5 (ts1),
    .ts2Bytes1Thru5 (ts2),
    .rx             (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] d,
    input logic       k,
    input logic       v,
    input logic       f
  );
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {rx.rxdata, rx.rxdatak, rx.rxvalid, rx.finishedOs};
    exp = {d, k, v, f};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got={d,k,v,f}=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    p2md_rstn = 1'b1;
    en_n = 1'b1;
    st = DETECT_QUIET;
    ts1 = '0;
    ts2 = '0;
    #2 p2md_rstn = 1'b0;
    #1 chk("rst", 8'h00, 0, 0, 0);
    step();
    step();
    chk("rst_hold", 8'h00, 0, 0, 0);

    p2md_rstn = 1'b1;
    en_n = 1'b0;
    st = POLLING_ACTIVE;
    step(); chk("idle_latch", 8'h00, 0, 0, 1);
    step(); chk("skp0", COM, 1, 1, 0);
    step(); chk("skp1", SKP, 1, 1, 0);
    step(); chk("skp2", SKP, 1, 1, 0);
    step(); chk("skp3", SKP, 1, 1, 1);
    step(); chk("skp_rep", COM, 1, 1, 0);

    en_n = 1'b1;
    step(); chk("dis0", 8'h00, 0, 0, 0);
    step();
    step(); chk("dis2", 8'h00, 0, 0, 0);
    en_n = 1'b0;
    step(); chk("resume", COM, 1, 1, 0);
    step(); chk("resume1", SKP, 1, 1, 0);

    st = POLLING_ACTIVE_START_TS1;
    ts1 = 40'h0504030201;
    step(); chk("skp_nocut", SKP, 1, 1, 0);
    step(); chk("skp_end", SKP, 1, 1, 1);
    step(); chk("ts1_com", COM, 1, 1, 0);
    step(); chk("ts1_s1", 8'h01, 0, 1, 0);
    step(); chk("ts1_s2", 8'h02, 0, 1, 0);
    ts1 = 40'h1514131211;
    step(); chk("ts1_s3_old", 8'h03, 0, 1, 0);
    step(); chk("ts1_s4_old", 8'h04, 0, 1, 0);
    step(); chk("ts1_s5_old", 8'h05, 0, 1, 0);
    step(); chk("ts1_id", TS1ID, 0, 1, 0);
    repeat (9) step();
    chk("ts1_s15", TS1ID, 0, 1, 1);
    step(); chk("ts1b_com", COM, 1, 1, 0);
    step(); chk("ts1b_s1_new", 8'h11, 0, 1, 0);
    repeat (4) step();
    chk("ts1b_s5_new", 8'h15, 0, 1, 0);
    step(); chk("ts1b_s6", TS1ID, 0, 1, 0);

    st = POLLING_CONFIG;
    ts2 = 40'h2524232221;
    step(); chk("ts1b_s7", TS1ID, 0, 1, 0);
    repeat (8) step();
    chk("ts1b_s15", TS1ID, 0, 1, 1);
    step(); chk("ts2_com", COM, 1, 1, 0);
    step(); chk("ts2_s1", 8'h21, 0, 1, 0);
    repeat (4) step();
    chk("ts2_s5", 8'h25, 0, 1, 0);
    step(); chk("ts2_s6", TS2ID, 0, 1, 0);

    #3 p2md_rstn = 1'b0;
    #1 chk("async_rst", 8'h00, 0, 0, 0);
    #2 p2md_rstn = 1'b1;
    step(); chk("post_rst_idle", 8'h00, 0, 0, 1);
    step(); chk("post_rst_ts2", COM, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
